// File: rtl/predictive_decoder.sv
// predictive_decoder
// Receiver side of the 3-tap linear predictor. Each accepted prediction error
// is added to the prediction formed from the decoder's own reconstructed
// history. The result is presented through a one-entry valid/ready output register.
//
// Ports:
//   Clk          clock, rising edge
//   reset        asynchronous active-low reset
//   w_ld         load w0_in..w2_in into the weight registers
//   w0_in..w2_in tap weights (w0 -> newest history sample, w2 -> oldest)
//   clr          synchronous history / sample counter clear (frame start)
//   err          received prediction error, two's complement
//   err_valid    err is valid
//   err_ready    block can take err this cycle
//   x            reconstructed sample
//   x_valid      x is valid
//   x_ready      downstream accepts x
//   sample_cnt   samples accepted since reset or clr (wraps)
module predictive_decoder #(
    parameter int unsigned W     = 9,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             w_ld,
    input  logic [W-1:0]     w0_in,
    input  logic [W-1:0]     w1_in,
    input  logic [W-1:0]     w2_in,
    input  logic             clr,
    input  logic [W-1:0]     err,
    input  logic             err_valid,
    output logic             err_ready,
    output logic [W-1:0]     x,
    output logic             x_valid,
    input  logic             x_ready,
    output logic [CNT_W-1:0] sample_cnt
);

    logic [W-1:0]     wr0_q, wr1_q, wr2_q;
    logic [W-1:0]     wr0_d, wr1_d, wr2_d;
    logic [W-1:0]     h1_q, h2_q, h3_q;
    logic [W-1:0]     h1_d, h2_d, h3_d;
    logic [W-1:0]     x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic [W-1:0]     hb1, hb2, hb3;
    logic [CNT_W-1:0] cnt_base;
    logic [W-1:0]     p0, p1, p2;
    logic [W-1:0]     x_hat, x_new;

    assign err_ready  = !x_valid_q || x_ready;
    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign sample_cnt = cnt_q;

    always_comb begin
        accept = err_valid && err_ready;

        // clr takes effect before the prediction, so a sample accepted in
        // the same cycle sees an all-zero history and a zero count.
        hb1      = clr ? '0 : h1_q;
        hb2      = clr ? '0 : h2_q;
        hb3      = clr ? '0 : h3_q;
        cnt_base = clr ? '0 : cnt_q;

        // Each product is kept to W bits before summing; wrap-around is
        // what keeps this bit-exact with the encoder.
        p0    = wr0_q * hb1;
        p1    = wr1_q * hb2;
        p2    = wr2_q * hb3;
        x_hat = p0 + p1 + p2;
        x_new = x_hat + err;

        h1_d      = hb1;
        h2_d      = hb2;
        h3_d      = hb3;
        cnt_d     = cnt_base;
        x_d       = x_q;
        x_valid_d = x_valid_q;

        if (accept) begin
            h3_d      = hb2;
            h2_d      = hb1;
            h1_d      = x_new;
            x_d       = x_new;
            x_valid_d = 1'b1;
            cnt_d     = cnt_base + CNT_W'(1);
        end else if (x_valid_q && x_ready) begin
            x_valid_d = 1'b0;
        end

        // Weights change at the edge; the sample above used the old ones.
        wr0_d = w_ld ? w0_in : wr0_q;
        wr1_d = w_ld ? w1_in : wr1_q;
        wr2_d = w_ld ? w2_in : wr2_q;
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            wr0_q     <= '0;
            wr1_q     <= '0;
            wr2_q     <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
            h3_q      <= '0;
            x_q       <= '0;
            x_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wr0_q     <= wr0_d;
            wr1_q     <= wr1_d;
            wr2_q     <= wr2_d;
            h1_q      <= h1_d;
            h2_q      <= h2_d;
            h3_q      <= h3_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_predictive_decoder.sv
module tb_predictive_decoder;

    localparam int W  = 9;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          reset = 1'b0;
    logic          w_ld = 1'b0;
    logic [W-1:0]  w0_in = '0, w1_in = '0, w2_in = '0;
    logic          clr = 1'b0;
    logic [W-1:0]  err = '0;
    logic          err_valid = 1'b0;
    logic          err_ready;
    logic [W-1:0]  x;
    logic          x_valid;
    logic          x_ready = 1'b0;
    logic [CW-1:0] sample_cnt;

    predictive_decoder #(.W(W), .CNT_W(CW)) dut (
        .Clk(Clk), .reset(reset), .w_ld(w_ld),
        .w0_in(w0_in), .w1_in(w1_in), .w2_in(w2_in),
        .clr(clr), .err(err), .err_valid(err_valid), .err_ready(err_ready),
        .x(x), .x_valid(x_valid), .x_ready(x_ready), .sample_cnt(sample_cnt)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: weights, list of reconstructed samples since the last
    // clear (newest first), output register and counter.
    int   mw[3];
    int   mhist[$];
    int   mx;
    bit   mxv;
    int   mcnt;
    bit   m_rdy;
    logic obs_rdy;

    function automatic void model_reset();
        mw = '{0, 0, 0};
        mhist.delete();
        mx = 0; mxv = 0; mcnt = 0;
    endfunction

    // One clock cycle: drive inputs at posedge+1, sample err_ready before
    // the edge, advance the model, return at posedge+1 of the next cycle.
    task automatic step(input bit ev, input int e, input bit xr,
                        input bit wl, input int a, input int b, input int c,
                        input bit cl);
        int pred;
        bit acc;
        err_valid = ev; err = e[W-1:0]; x_ready = xr;
        w_ld = wl; w0_in = a[W-1:0]; w1_in = b[W-1:0]; w2_in = c[W-1:0];
        clr = cl;
        #1;
        obs_rdy = err_ready;
        m_rdy = !mxv || xr;
        acc = ev && m_rdy;
        if (cl) begin
            mhist.delete();
            mcnt = 0;
        end
        if (acc) begin
            pred = 0;
            for (int i = 0; i < 3; i++)
                if (i < mhist.size()) pred += mw[i] * mhist[i];
            mx = (pred + e) % 512;
            mhist.push_front(mx);
            if (mhist.size() > 3) void'(mhist.pop_back());
            mxv = 1;
            mcnt = (mcnt + 1) % 65536;
        end else if (mxv && xr) begin
            mxv = 0;
        end
        if (wl) mw = '{a, b, c};
        @(posedge Clk);
        #1;
        err_valid = 1'b0; w_ld = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        n_checks++;
        if (x_valid !== 1'b0 || x !== '0 || sample_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: x_valid=%0b x=%0d cnt=%0d, required 0/0/0", x_valid, x, sample_cnt);
        end
        n_checks++;
        if (err_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_err_ready: got %0b required 1", err_ready);
        end
        #10 reset = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_basic();
        int errs[3] = '{5, 3, 511};
        int exp_x[3] = '{5, 8, 7};
        step(0, 0, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, errs[i], 1, 0, 0, 0, 0, 0);
            n_checks++;
            if (x !== exp_x[i][W-1:0] || x_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_x%0d: x=%0d valid=%0b, required x=%0d valid=1", i, x, x_valid, exp_x[i]);
            end
        end
        n_checks++;
        if (sample_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL basic_cnt: got %0d required 3", sample_cnt);
        end
    endtask

    task automatic test_neg_weight();
        int errs[3] = '{10, 0, 0};
        int exp_x[3] = '{10, 20, 30};
        step(0, 0, 1, 1, 2, 511, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, errs[i], 1, 0, 0, 0, 0, 0);
            n_checks++;
            if (x !== exp_x[i][W-1:0]) begin
                n_fail++;
                $display("FAIL neg_weight_x%0d: got %0d required %0d", i, x, exp_x[i]);
            end
        end
    endtask

    task automatic test_wrap();
        step(1, 500, 1, 1, 1, 0, 0, 1);
        n_checks++;
        if (x !== 9'd500) begin
            n_fail++;
            $display("FAIL wrap_prime: got %0d required 500", x);
        end
        step(1, 20, 1, 0, 0, 0, 0, 0);
        n_checks++;
        if (x !== 9'd8) begin
            n_fail++;
            $display("FAIL wrap_x: got %0d required 8", x);
        end
    endtask

    task automatic test_backpressure();
        step(0, 0, 1, 0, 0, 0, 0, 1);
        step(1, 4, 1, 0, 0, 0, 0, 0);
        n_checks++;
        if (x !== 9'd4) begin
            n_fail++;
            $display("FAIL bp_first: got %0d required 4", x);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 6, 0, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs_rdy !== 1'b0 || x !== 9'd4 || x_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stall%0d: err_ready=%0b x=%0d valid=%0b, required 0/4/1", i, obs_rdy, x, x_valid);
            end
        end
        step(1, 6, 1, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs_rdy !== 1'b1 || x !== 9'd10 || sample_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_release: err_ready=%0b x=%0d cnt=%0d, required 1/10/2", obs_rdy, x, sample_cnt);
        end
        step(0, 0, 1, 0, 0, 0, 0, 0);
        n_checks++;
        if (x_valid !== 1'b0 || x !== 9'd10) begin
            n_fail++;
            $display("FAIL bp_drain: valid=%0b x=%0d, required 0/10", x_valid, x);
        end
    endtask

    task automatic test_coincident();
        step(0, 0, 1, 1, 1, 1, 1, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 1, 0, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0, 0, 0, 0);
        step(1, 7, 1, 0, 0, 0, 0, 1);
        n_checks++;
        if (x !== 9'd7 || sample_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL clr_accept: x=%0d cnt=%0d, required 7/1", x, sample_cnt);
        end
        step(1, 5, 1, 1, 0, 0, 0, 0);
        n_checks++;
        if (x !== 9'd12) begin
            n_fail++;
            $display("FAIL wld_old_weights: got %0d required 12", x);
        end
        step(1, 13, 1, 0, 0, 0, 0, 0);
        n_checks++;
        if (x !== 9'd13) begin
            n_fail++;
            $display("FAIL wld_new_weights: got %0d required 13", x);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit ev = ($urandom_range(0, 3) != 0);
            bit xr = ($urandom_range(0, 9) < 7);
            bit wl = ($urandom_range(0, 19) == 0);
            bit cl = ($urandom_range(0, 24) == 0);
            step(ev, $urandom_range(0, 511), xr, wl,
                 $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511), cl);
            n_checks++;
            if (obs_rdy !== m_rdy || x !== mx[W-1:0] || x_valid !== mxv || sample_cnt !== mcnt[CW-1:0]) begin
                n_fail++;
                $display("FAIL random_%0d: rdy=%0b x=%0d valid=%0b cnt=%0d, required rdy=%0b x=%0d valid=%0b cnt=%0d",
                         i, obs_rdy, x, x_valid, sample_cnt, m_rdy, mx, mxv, mcnt);
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(0, 0, 1, 1, 3, 4, 5, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (x_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: valid=%0b required 1", x_valid);
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (x_valid !== 1'b0 || x !== '0 || sample_cnt !== '0 || err_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: valid=%0b x=%0d cnt=%0d rdy=%0b, required 0/0/0/1", x_valid, x, sample_cnt, err_ready);
        end
        #3 reset = 1'b1;
        @(posedge Clk); #1;
        step(1, 9, 1, 0, 0, 0, 0, 0);
        n_checks++;
        if (x !== 9'd9 || x_valid !== 1'b1 || sample_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_after: x=%0d valid=%0b cnt=%0d, required 9/1/1", x, x_valid, sample_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_weight();
        test_wrap();
        test_backpressure();
        test_coincident();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/predictive_decoder.md
# predictive_decoder

Receiver-side counterpart of the 3-tap linear predictor. It consumes the 9-bit prediction-error stream and reconstructs the original sample stream by forming the same 3-tap prediction from its own reconstructed history, then adding the received error. It sits at the far end of the residual link and feeds reconstructed samples to the downstream consumer through a valid/ready handshake.

## Interface
Parameters:
- W, 9: sample, error and weight width; all arithmetic is modulo 2^W.
- CNT_W, 16: width of the reconstructed-sample counter.

Ports:
- Clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- w_ld  in  1  load w0_in/w1_in/w2_in into the weight registers.
- w0_in, w1_in, w2_in  in  W  tap weights; w0 applies to the newest history sample, w2 to the oldest.
- clr  in  1  synchronous history clear (frame start).
- err  in  W  received prediction error, two's complement.
- err_valid  in  1  err is valid.
- err_ready  out  1  block accepts err this cycle.
- x  out  W  reconstructed sample.
- x_valid  out  1  x is valid.
- x_ready  in  1  downstream accepts x.
- sample_cnt  out  CNT_W  number of samples accepted since reset or clr, wraps.

## Operation
- State: weights wr0..wr2, history h1 (newest), h2, h3 (oldest), output register x plus x_valid, sample_cnt.
- Accept when err_valid && err_ready; err_ready = !x_valid || x_ready (combinational).
- On accept: x_hat = (wr0*h1 + wr1*h2 + wr2*h3) mod 2^W, with each product truncated to W bits before summing. x <= (x_hat + err) mod 2^W. The history then shifts: h3 <= h2, h2 <= h1, h1 <= new x. x_valid <= 1, and sample_cnt increments.
- Output register: x_valid clears when x_valid && x_ready && no accept in the same cycle. x holds stable while x_valid && !x_ready.
- w_ld updates wr0..wr2 at the edge. A sample accepted in the same cycle uses the old weights.
- clr zeroes h1..h3 and sample_cnt. When clr and accept coincide, the accepted sample uses the zeroed history, so x = err. After that edge, h1 = x, h2 = h3 = 0, and sample_cnt = 1. clr does not affect x, x_valid or the weights.
- No overflow detection. Wrap-around is the required behaviour, because it keeps the decoder bit-exact with the encoder.

## Timing
- Reset values: x = 0, x_valid = 0, sample_cnt = 0, h1..h3 = 0, wr0..wr2 = 0. err_ready = 1 immediately (combinational from x_valid).
- Latency: x_valid rises on the edge that accepts err, so x is visible 1 cycle after acceptance.
- Throughput: 1 sample/cycle while x_ready stays high.
- Backpressure: with x_valid=1 and x_ready=0, err_ready=0, nothing is accepted and x holds.
- Reset asserted mid-stream: outputs go to reset values asynchronously. A held x is discarded and not re-presented.
- First samples after reset or clr use zero history for missing taps. With all-zero weights, x = err.

## Test plan
- Weights (1,0,0), x_ready=1, err = 5, 3, 0x1FF -> x = 5, 8, 7 on consecutive cycles; sample_cnt = 3.
- Weights (2,0x1FF,0), err = 10, 0, 0 -> x = 10, 20, 30.
- Wrap-around: weights (1,0,0), history primed so h1 = 500, err = 20 -> x = 8.
- Backpressure with weights (1,0,0): err = 4, then x_ready=0 for 3 cycles while err_valid=1 with err = 6. Required: x = 4 held, err_ready=0 during the stall, then x = 10 after x_ready rises.
- Coincident events: clr and accept of err = 7 in the same cycle with weights (1,1,1) and nonzero history -> x = 7, sample_cnt = 1. With w_ld to (0,0,0) in the same cycle as an accept, that sample uses the old weights and the next sample gives x = err.
- Reset: assert reset while x_valid=1 and x_ready=0 -> x_valid = 0 and x = 0 without a clock edge. After release, history and weights are 0, so err = 9 gives x = 9.
